// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg: phase codes and sequencer state encoding shared by the CPU control path.
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [1:0] FETCH1  = 2'b00;
  localparam logic [1:0] DECODE  = 2'b01;
  localparam logic [1:0] EXECUTE = 2'b10;
  localparam logic [1:0] WRITEB  = 2'b11;

  localparam logic [2:0] SQ_IDLE     = 3'd0;
  localparam logic [2:0] SQ_FETCH    = 3'd1;
  localparam logic [2:0] SQ_DECODE   = 3'd2;
  localparam logic [2:0] SQ_MEM_WAIT = 3'd3;
  localparam logic [2:0] SQ_EXECUTE  = 3'd4;
  localparam logic [2:0] SQ_WRITEB   = 3'd5;
  localparam logic [2:0] SQ_HALT     = 3'd6;

  localparam int MEM_WAIT_MAX_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE     = SQ_IDLE,
    S_FETCH    = SQ_FETCH,
    S_DECODE   = SQ_DECODE,
    S_MEM_WAIT = SQ_MEM_WAIT,
    S_EXECUTE  = SQ_EXECUTE,
    S_WRITEB   = SQ_WRITEB,
    S_HALT     = SQ_HALT
  } seq_state_e;

  // MEM_WAIT keeps presenting the DECODE phase so the decoder holds its memory request.
  function automatic logic [1:0] phase_of(input seq_state_e s);
    logic [1:0] ph;
    ph = FETCH1;
    case (s)
      S_DECODE, S_MEM_WAIT: ph = DECODE;
      S_EXECUTE:            ph = EXECUTE;
      S_WRITEB:             ph = WRITEB;
      default:              ph = FETCH1;
    endcase
    return ph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cycle_sequencer_if: control/status bundle between debug controls and the sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
interface cycle_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             run;
  logic             single_mode;
  logic             step;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;
  logic [1:0]       estado;
  logic             stall;
  logic             instr_done;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, single_mode, step, mem_req, mem_ready, halt_req,
    input  estado, stall, instr_done, halted, mem_timeout, instr_count
  );

  modport slave (
    input  run, single_mode, step, mem_req, mem_ready, halt_req,
    output estado, stall, instr_done, halted, mem_timeout, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wait_timer: saturating memory-wait counter with terminal-count flag.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MAX = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  input  wire logic i_clear,
  input  wire logic i_inc,
  output logic      o_tc
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(1);
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt >= W'(MAX));
endmodule
`default_nettype wire

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cycle_sequencer: instruction phase FSM with run/step, memory-wait timeout, halt and retire count.
// Rev 1.0
// ---------------------------------------------------------------------------
module cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
  parameter int CNT_W        = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  cycle_sequencer_if.slave bus
);
  seq_state_e       r_state;
  seq_state_e       w_next;
  logic             r_halt_pend;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_count;
  logic             w_load;
  logic             w_clear;
  logic             w_inc;
  logic             w_tc;
  logic             w_set_timeout;
  logic             w_retire;
  logic             w_in_instr;

  mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_clear       = 1'b0;
    w_inc         = 1'b0;
    w_set_timeout = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.halt_req) begin
          w_next = S_HALT;
        end else if (bus.run && (!bus.single_mode || bus.step)) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        if (!bus.mem_req || bus.mem_ready) begin
          w_next = S_EXECUTE;
        end else begin
          w_next = S_MEM_WAIT;
          w_load = 1'b1;
        end
      end
      // mem_ready wins over a timeout landing on the same cycle.
      S_MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_next  = S_EXECUTE;
          w_clear = 1'b1;
        end else if (w_tc) begin
          w_next        = S_HALT;
          w_set_timeout = 1'b1;
          w_clear       = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_EXECUTE: w_next = S_WRITEB;
      S_WRITEB: begin
        w_retire = 1'b1;
        if (r_halt_pend || bus.halt_req) begin
          w_next = S_HALT;
        end else if (!bus.run || bus.single_mode) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (!bus.run) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_in_instr = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_MEM_WAIT) || (r_state == S_EXECUTE);

  // A pending halt is consumed at the boundary or dropped when a timeout halts first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt_pend <= 1'b0;
    end else if (r_state == S_WRITEB || w_next == S_HALT) begin
      r_halt_pend <= 1'b0;
    end else if (w_in_instr && bus.halt_req) begin
      r_halt_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_timeout <= 1'b0;
      r_count       <= '0;
    end else begin
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.estado      = phase_of(r_state);
  assign bus.stall       = (r_state == S_IDLE) || (r_state == S_MEM_WAIT) || (r_state == S_HALT);
  assign bus.instr_done  = (r_state == S_WRITEB);
  assign bus.halted      = (r_state == S_HALT);
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.instr_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cycle_sequencer: directed stimulus with per-cycle reference model comparison.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cycle_sequencer;
  localparam int MAXW = 15;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   chk_en   = 1'b0;

  cycle_sequencer_if #(.CNT_W(CW)) bus ();

  cycle_sequencer #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: where the instruction is (phase index) plus the facts the spec tracks.
  localparam int P_IDLE = 0, P_F = 1, P_D = 2, P_E = 3, P_W = 4, P_MW = 5, P_H = 6;
  int ph_estado [0:6] = '{0, 0, 1, 2, 3, 1, 0};
  int ph_stall  [0:6] = '{1, 0, 0, 0, 0, 1, 1};
  int m_ph = P_IDLE;
  int m_waited = 0;
  int m_retired = 0;
  bit m_pend = 1'b0;
  bit m_to = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= P_IDLE; m_waited <= 0; m_retired <= 0; m_pend <= 1'b0; m_to <= 1'b0;
    end else begin
      if (m_ph inside {P_F, P_D, P_MW, P_E} && bus.halt_req) m_pend <= 1'b1;
      case (m_ph)
        P_IDLE: if (bus.halt_req) m_ph <= P_H;
                else if (bus.run && (!bus.single_mode || bus.step)) m_ph <= P_F;
        P_F: m_ph <= P_D;
        P_D: if (bus.mem_req && !bus.mem_ready) begin m_ph <= P_MW; m_waited <= 1; end
             else m_ph <= P_E;
        P_MW: if (bus.mem_ready) m_ph <= P_E;
              else if (m_waited >= MAXW) begin m_ph <= P_H; m_to <= 1'b1; m_pend <= 1'b0; end
              else m_waited <= m_waited + 1;
        P_E: m_ph <= P_W;
        P_W: begin
          m_retired <= (m_retired + 1) % (1 << CW);
          m_pend <= 1'b0;
          if (m_pend || bus.halt_req) m_ph <= P_H;
          else if (!bus.run || bus.single_mode) m_ph <= P_IDLE;
          else m_ph <= P_F;
        end
        P_H: if (!bus.run) m_ph <= P_IDLE;
        default: m_ph <= P_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_estado", 32'(bus.estado), 32'(ph_estado[m_ph]));
      chk("m_stall", 32'(bus.stall), 32'(ph_stall[m_ph]));
      chk("m_instr_done", 32'(bus.instr_done), 32'(m_ph == P_W));
      chk("m_halted", 32'(bus.halted), 32'(m_ph == P_H));
      chk("m_mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
      chk("m_instr_count", 32'(bus.instr_count), 32'(m_retired));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.run = 0; bus.single_mode = 0; bus.step = 0;
    bus.mem_req = 0; bus.mem_ready = 0; bus.halt_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_estado", 32'(bus.estado), 0);
    chk("rst_stall", 32'(bus.stall), 1);
    chk("rst_count", 32'(bus.instr_count), 0);
    chk("rst_halted", 32'(bus.halted), 0);

    // Free-running instructions, no memory wait.
    bus.run = 1;
    tick(1); chk("t1_fetch", 32'(bus.estado), 0); chk("t1_stall", 32'(bus.stall), 0);
    tick(1); chk("t1_decode", 32'(bus.estado), 1);
    tick(1); chk("t1_exec", 32'(bus.estado), 2);
    tick(1); chk("t1_wb", 32'(bus.estado), 3); chk("t1_done", 32'(bus.instr_done), 1);
    tick(5); chk("t1_count2", 32'(bus.instr_count), 2);
    bus.run = 0;
    tick(4); chk("t1_idle", 32'(bus.stall), 1); chk("t1_count3", 32'(bus.instr_count), 3);

    // Three-cycle memory wait.
    bus.run = 1;
    tick(1); bus.mem_req = 1; bus.run = 0;
    tick(1); chk("t2_decode", 32'(bus.estado), 1); chk("t2_dec_stall", 32'(bus.stall), 0);
    tick(1); chk("t2_mw1", 32'(bus.stall), 1);
    tick(1); chk("t2_mw2", 32'(bus.estado), 1);
    tick(1); chk("t2_mw3", 32'(bus.stall), 1); bus.mem_ready = 1;
    tick(1); chk("t2_exec", 32'(bus.estado), 2); bus.mem_req = 0; bus.mem_ready = 0;
    tick(2); chk("t2_count", 32'(bus.instr_count), 4);

    // Memory never answers: timeout halt.
    bus.run = 1; bus.mem_req = 1;
    tick(2);
    for (int i = 0; i < MAXW; i++) begin
      tick(1); chk("t3_wait_stall", 32'(bus.stall), 1);
    end
    tick(1); chk("t3_halted", 32'(bus.halted), 1); chk("t3_timeout", 32'(bus.mem_timeout), 1);
    bus.run = 0; bus.mem_req = 0;
    tick(1); chk("t3_unhalt", 32'(bus.halted), 0); chk("t3_sticky", 32'(bus.mem_timeout), 1);

    // Single-step, with an ignored step during EXECUTE.
    bus.single_mode = 1; bus.run = 1;
    tick(1); chk("t4_wait_step", 32'(bus.stall), 1);
    bus.step = 1; tick(1); bus.step = 0;
    tick(2); bus.step = 1; tick(1); bus.step = 0;
    tick(1); chk("t4_idle_a", 32'(bus.stall), 1);
    tick(1); chk("t4_idle_b", 32'(bus.stall), 1);
    bus.step = 1; tick(1); bus.step = 0;
    tick(4); chk("t4_count", 32'(bus.instr_count), 6);
    bus.single_mode = 0;

    // Halt request pulse in FETCH, then halt request from IDLE.
    tick(1); bus.halt_req = 1;
    tick(1); bus.halt_req = 0;
    tick(2); chk("t5_done", 32'(bus.instr_done), 1);
    tick(1); chk("t5_halt", 32'(bus.halted), 1); chk("t5_count", 32'(bus.instr_count), 7);
    bus.run = 0;
    tick(1); chk("t5_idle", 32'(bus.halted), 0);
    bus.halt_req = 1; tick(1); bus.halt_req = 0;
    chk("t5_idle_halt", 32'(bus.halted), 1); chk("t5_no_instr", 32'(bus.instr_count), 7);
    tick(1);

    // Asynchronous reset mid-EXECUTE, then counter wrap.
    bus.run = 1;
    tick(3); chk("t6_exec", 32'(bus.estado), 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_estado", 32'(bus.estado), 0);
    chk("t6_async_stall", 32'(bus.stall), 1);
    chk("t6_async_count", 32'(bus.instr_count), 0);
    chk("t6_async_timeout", 32'(bus.mem_timeout), 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(1);
    tick(60); chk("t6_count15", 32'(bus.instr_count), 15);
    tick(4);  chk("t6_wrap", 32'(bus.instr_count), 0);
    bus.run = 0;
    tick(4);
    chk("t6_final_idle", 32'(bus.stall), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
